// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM access sequencer: FSM encoding, SRAM bus
// widths and the byte-address to SRAM-word mapping.
package mem_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int WIDX_W  = SRAM_AW - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic [WIDX_W-1:0] widx;
        logic              err;
    } addr_map_t;

    // The index wraps modulo 2^17; out-of-window or misaligned addresses are
    // flagged but still mapped so the access can run to completion.
    function automatic addr_map_t map_addr(input logic [31:0] addr,
                                           input logic [31:0] base);
        logic [31:0] off;
        addr_map_t   r;
        off    = addr - base;
        r.widx = off[WIDX_W+1:2];
        r.err  = (addr < base) || (addr[1:0] != 2'b00) || (off >= 32'h0008_0000);
        return r;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM half-word access; tc flags the last cycle.
module sram_wait_counter #(
    parameter int               CNT_W  = 4,
    parameter logic [CNT_W-1:0] TC_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: splits each 32-bit load/store into two half-word
// accesses on an asynchronous 16-bit SRAM and stalls the pipeline meanwhile.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_result,
    input  logic [31:0]        ST_val,
    output logic               freeze,
    output logic               ready,
    output logic [31:0]        read_data,
    output logic               addr_err,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [SRAM_DW-1:0] SRAM_DQ_out,
    output logic               SRAM_DQ_oe,
    input  logic [SRAM_DW-1:0] SRAM_DQ_in,
    output logic               SRAM_WE_N
);

    logic [1:0]        state_q,     state_d;
    logic [WIDX_W-1:0] widx_q,      widx_d;
    logic [31:0]       data_q,      data_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              store_q,     store_d;
    logic              err_q,       err_d;

    logic      req;
    logic      active;
    logic      tc;
    logic      cnt_clr;
    logic      cnt_en;
    addr_map_t amap;

    assign req    = MEM_R_EN | MEM_W_EN;
    assign amap   = map_addr(ALU_result, BASE_ADDR);
    assign active = (state_q == ST_LOW) || (state_q == ST_HIGH);

    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        data_d      = data_q;
        read_data_d = read_data_q;
        store_d     = store_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_LOW;
                    widx_d  = amap.widx;
                    err_d   = amap.err;
                    store_d = MEM_W_EN;
                    data_d  = ST_val;
                end
            end
            ST_LOW: begin
                if (tc) begin
                    state_d = ST_HIGH;
                    if (!store_q) begin
                        data_d[15:0] = SRAM_DQ_in;
                    end
                end
            end
            ST_HIGH: begin
                if (tc) begin
                    state_d = ST_DONE;
                    if (!store_q) begin
                        data_d[31:16] = SRAM_DQ_in;
                        read_data_d   = {SRAM_DQ_in, data_q[15:0]};
                    end
                end
            end
            // The pipeline advances on the DONE edge, so the request still
            // visible here belongs to the finished access and is not restarted.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            widx_q      <= '0;
            data_q      <= '0;
            read_data_q <= '0;
            store_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            data_q      <= data_d;
            read_data_q <= read_data_d;
            store_q     <= store_d;
            err_q       <= err_d;
        end
    end

    assign cnt_clr = (state_d != state_q);
    assign cnt_en  = active && !tc;

    sram_wait_counter #(
        .CNT_W  (4),
        .TC_VAL (4'(WAIT_CYCLES - 1))
    ) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tc)
    );

    // WE_N is released on the last wait cycle of each half so data is held
    // across the rising strobe.
    always_comb begin
        SRAM_ADDR   = '0;
        SRAM_DQ_out = '0;
        SRAM_DQ_oe  = 1'b0;
        SRAM_WE_N   = 1'b1;
        if (active) begin
            SRAM_ADDR = {widx_q, (state_q == ST_HIGH)};
            if (store_q) begin
                SRAM_DQ_out = (state_q == ST_HIGH) ? data_q[31:16] : data_q[15:0];
                SRAM_DQ_oe  = 1'b1;
                SRAM_WE_N   = tc;
            end
        end
    end

    assign freeze    = req && (state_q != ST_DONE);
    assign ready     = (state_q == ST_DONE);
    assign addr_err  = ready && err_q;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 16-bit SRAM model.
module tb_mem_access_ctrl;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_result;
    logic [31:0] ST_val;
    logic        freeze;
    logic        ready;
    logic [31:0] read_data;
    logic        addr_err;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic [15:0] SRAM_DQ_in;
    logic        SRAM_WE_N;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          rdy;
        int          frz;
        logic        frz_rdy;
        logic [31:0] rdata;
        logic        aerr;
        int          err_cnt;
        int          we_lo;
        int          we_hi;
        logic [17:0] a_lo;
        logic [17:0] a_hi;
        logic [15:0] d_lo;
        logic [15:0] d_hi;
        logic        oe_lo;
    } res_t;

    mem_access_ctrl #(
        .WAIT_CYCLES (W),
        .BASE_ADDR   (32'd1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .ALU_result  (ALU_result),
        .ST_val      (ST_val),
        .freeze      (freeze),
        .ready       (ready),
        .read_data   (read_data),
        .addr_err    (addr_err),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ_out (SRAM_DQ_out),
        .SRAM_DQ_oe  (SRAM_DQ_oe),
        .SRAM_DQ_in  (SRAM_DQ_in),
        .SRAM_WE_N   (SRAM_WE_N)
    );

    always #5 clk = ~clk;

    logic [15:0] sram [0:262143];
    assign SRAM_DQ_in = sram[SRAM_ADDR];
    always @(posedge clk) begin
        if (!SRAM_WE_N && SRAM_DQ_oe) sram[SRAM_ADDR] <= SRAM_DQ_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        @(negedge clk);
    endtask

    // Starts at a negedge (cycle 0), returns at the negedge opening the cycle
    // after ready with the request still driven, so callers can issue back-to-back.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] sd, output res_t r);
        r = '{rdy: -1, frz: 0, frz_rdy: 1'b0, rdata: '0, aerr: 1'b0, err_cnt: 0,
              we_lo: 0, we_hi: 0, a_lo: '0, a_hi: '0, d_lo: '0, d_hi: '0, oe_lo: 1'b0};
        MEM_R_EN   = rd;
        MEM_W_EN   = wr;
        ALU_result = addr;
        ST_val     = sd;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (ready) begin
                r.rdy     = c;
                r.frz_rdy = freeze;
                r.rdata   = read_data;
                r.aerr    = addr_err;
                break;
            end
            r.frz     += int'(freeze);
            r.err_cnt += int'(addr_err);
            if (!SRAM_WE_N) begin
                if (SRAM_ADDR[0]) r.we_hi++;
                else              r.we_lo++;
            end
            if (c == 1) begin
                r.a_lo     = SRAM_ADDR;
                r.d_lo     = SRAM_DQ_out;
                r.oe_lo    = SRAM_DQ_oe;
                ALU_result = 32'hFFFF_FFF0;
                ST_val     = ~sd;
            end
            if (c == W + 1) begin
                r.a_hi = SRAM_ADDR;
                r.d_hi = SRAM_DQ_out;
            end
            @(negedge clk);
        end
        if (r.rdy < 0) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    res_t r;
    res_t r2;
    int   nrdy;

    initial begin
        rst        = 1'b1;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        ALU_result = '0;
        ST_val     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_freeze",  32'(freeze),      32'd0);
        check("rst_ready",   32'(ready),       32'd0);
        check("rst_addrerr", 32'(addr_err),    32'd0);
        check("rst_rdata",   read_data,        32'd0);
        check("rst_addr",    32'(SRAM_ADDR),   32'd0);
        check("rst_dq",      32'(SRAM_DQ_out), 32'd0);
        check("rst_oe",      32'(SRAM_DQ_oe),  32'd0);
        check("rst_we_n",    32'(SRAM_WE_N),   32'd1);
        rst = 1'b0;
        @(negedge clk);

        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, r);
        idle_bus();
        check("st0_rdy_cyc", r.rdy,           32'd7);
        check("st0_frz_cnt", r.frz,           32'd7);
        check("st0_frz_rdy", 32'(r.frz_rdy),  32'd0);
        check("st0_a_lo",    32'(r.a_lo),     32'd0);
        check("st0_d_lo",    32'(r.d_lo),     32'h0000BEEF);
        check("st0_oe_lo",   32'(r.oe_lo),    32'd1);
        check("st0_a_hi",    32'(r.a_hi),     32'd1);
        check("st0_d_hi",    32'(r.d_hi),     32'h0000DEAD);
        check("st0_we_lo",   r.we_lo,         32'd2);
        check("st0_we_hi",   r.we_hi,         32'd2);
        check("st0_aerr",    32'(r.aerr),     32'd0);

        access(1'b1, 1'b0, 32'd1024, 32'd0, r);
        idle_bus();
        check("ld0_rdy_cyc", r.rdy,          32'd7);
        check("ld0_rdata",   r.rdata,        32'hDEADBEEF);
        check("ld0_frz_rdy", 32'(r.frz_rdy), 32'd0);
        check("ld0_aerr",    32'(r.aerr),    32'd0);
        check("ld0_we",      r.we_lo + r.we_hi, 32'd0);
        check("ld0_oe",      32'(r.oe_lo),   32'd0);

        access(1'b0, 1'b1, 32'd1028, 32'h0BADF00D, r);
        access(1'b1, 1'b0, 32'd1028, 32'd0, r2);
        idle_bus();
        check("b2b_st_a_lo", 32'(r.a_lo),  32'd2);
        check("b2b_st_a_hi", 32'(r.a_hi),  32'd3);
        check("b2b_ld_rdy",  r2.rdy,       32'd7);
        check("b2b_ld_a_lo", 32'(r2.a_lo), 32'd2);
        check("b2b_ld_data", r2.rdata,     32'h0BADF00D);

        access(1'b0, 1'b1, 32'd1022, 32'h56781234, r);
        idle_bus();
        check("err_st_aerr", 32'(r.aerr),   32'd1);
        check("err_st_a_lo", 32'(r.a_lo),   32'h3FFFE);
        check("err_st_rdy",  r.rdy,         32'd7);
        access(1'b1, 1'b0, 32'd1022, 32'd0, r);
        idle_bus();
        check("err_ld_aerr",  32'(r.aerr),  32'd1);
        check("err_ld_pulse", r.err_cnt,    32'd0);
        check("err_ld_a_hi",  32'(r.a_hi),  32'h3FFFF);
        check("err_ld_data",  r.rdata,      32'h56781234);
        #1;
        check("err_after",    32'(addr_err), 32'd0);

        access(1'b1, 1'b0, 32'd525308, 32'd0, r);
        idle_bus();
        check("top_ld_aerr", 32'(r.aerr), 32'd0);
        check("top_ld_a_lo", 32'(r.a_lo), 32'h3FFFE);
        check("top_ld_data", r.rdata,     32'h56781234);

        access(1'b1, 1'b0, 32'd525312, 32'd0, r);
        idle_bus();
        check("oob_ld_aerr", 32'(r.aerr), 32'd1);
        check("oob_ld_a_lo", 32'(r.a_lo), 32'd0);
        check("oob_ld_data", r.rdata,     32'hDEADBEEF);

        access(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, r);
        idle_bus();
        check("both_we",    r.we_lo + r.we_hi, 32'd4);
        check("both_a_lo",  32'(r.a_lo),       32'd8);
        check("both_rdata", r.rdata,           32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1040, 32'd0, r);
        check("both_ld",    r.rdata,           32'hCAFEF00D);

        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b1;
        ALU_result = 32'd1044;
        ST_val     = 32'h11112222;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_we_n_pre", 32'(SRAM_WE_N), 32'd0);
        rst      = 1'b1;
        MEM_W_EN = 1'b0;
        @(negedge clk);
        #1;
        check("mid_we_n",  32'(SRAM_WE_N),  32'd1);
        check("mid_oe",    32'(SRAM_DQ_oe), 32'd0);
        check("mid_freeze", 32'(freeze),    32'd0);
        check("mid_ready", 32'(ready),      32'd0);
        check("mid_rdata", read_data,       32'd0);
        check("mid_addr",  32'(SRAM_ADDR),  32'd0);
        rst  = 1'b0;
        nrdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            nrdy += int'(ready);
        end
        check("mid_no_ready", nrdy, 32'd0);
        @(negedge clk);
        access(1'b1, 1'b0, 32'd1024, 32'd0, r);
        idle_bus();
        check("post_rst_rdy",  r.rdy,   32'd7);
        check("post_rst_data", r.rdata, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
